// File: rtl/lockstep_miter_checker.sv
// N-lane lockstep comparator with optional lead-lane delay, sticky first-failure capture and saturating count.
// Latency: mismatch/capture registered one cycle after the lagging lanes are sampled; no backpressure.
module lockstep_miter_checker #(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int DELAY = 0,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic [LANES*WIDTH-1:0] lane_data_i,
    input  logic [LANES-1:0]       lane_valid_i,
    output logic                   mismatch_o,
    output logic                   err_o,
    output logic [LANES-2:0]       err_lane_o,
    output logic [CNT_W-1:0]       err_cycle_o,
    output logic [WIDTH-1:0]       err_xor_o,
    output logic [CNT_W-1:0]       mismatch_cnt_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [3:0] FILL_LAST = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;

    if (LANES < 2 || LANES > 4) begin : g_bad_lanes
        $error("lockstep_miter_checker: LANES must be 2..4");
    end
    if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
        $error("lockstep_miter_checker: DELAY must be 0..15");
    end

    logic [WIDTH-1:0] lead_dat;
    logic             lead_vld;

    // Lead lane is re-timed to line up with the lagging lanes; runs in every state.
    if (DELAY == 0) begin : g_no_dly
        assign lead_dat = lane_data_i[WIDTH-1:0];
        assign lead_vld = lane_valid_i[0];
    end else begin : g_dly
        logic [WIDTH-1:0] dly_dat [DELAY];
        logic [DELAY-1:0] dly_vld;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DELAY; i++) begin
                    dly_dat[i] <= '0;
                    dly_vld[i] <= 1'b0;
                end
            end else begin
                dly_dat[0] <= lane_data_i[WIDTH-1:0];
                dly_vld[0] <= lane_valid_i[0];
                for (int i = 1; i < DELAY; i++) begin
                    dly_dat[i] <= dly_dat[i-1];
                    dly_vld[i] <= dly_vld[i-1];
                end
            end
        end

        assign lead_dat = dly_dat[DELAY-1];
        assign lead_vld = dly_vld[DELAY-1];
    end

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       fill_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [LANES-2:0] lane_mis;
    logic [WIDTH-1:0] first_xor;
    logic             active;
    logic             cmp_mis;
    logic             err_hold;

    // Walk lanes high to low so the lowest disagreeing lane provides the XOR.
    always_comb begin
        lane_mis  = '0;
        first_xor = '0;
        for (int k = LANES - 1; k >= 1; k--) begin
            lane_mis[k-1] = (lane_valid_i[k] != lead_vld) ||
                            (lane_valid_i[k] && lead_vld &&
                             (lane_data_i[k*WIDTH +: WIDTH] != lead_dat));
            if (lane_mis[k-1]) begin
                first_xor = lead_dat ^ lane_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign active   = en_i && (state == CHECK || state == FAIL);
    assign cmp_mis  = active && (|lane_mis);
    assign err_hold = err_o && !clr_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_i) state_nxt = (DELAY > 0) ? FILL : CHECK;
            FILL: begin
                if (!en_i)                       state_nxt = IDLE;
                else if (fill_cnt == FILL_LAST)  state_nxt = CHECK;
            end
            CHECK: begin
                if (!en_i)        state_nxt = IDLE;
                else if (cmp_mis) state_nxt = FAIL;
            end
            FAIL:    if (clr_i && !cmp_mis) state_nxt = en_i ? CHECK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
            cyc_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= (state == FILL) ? fill_cnt + 4'd1 : 4'd0;
            if ((state == IDLE || state == FILL) && state_nxt == CHECK) begin
                cyc_cnt <= '0;
            end else if (active && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

    // A clear in the same cycle as a mismatch re-arms capture for that mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_o     <= 1'b0;
            err_o          <= 1'b0;
            err_lane_o     <= '0;
            err_cycle_o    <= '0;
            err_xor_o      <= '0;
            mismatch_cnt_o <= '0;
        end else begin
            mismatch_o <= cmp_mis;
            if (cmp_mis && !err_hold) begin
                err_o       <= 1'b1;
                err_lane_o  <= lane_mis;
                err_cycle_o <= cyc_cnt;
                err_xor_o   <= first_xor;
            end else if (clr_i) begin
                err_o       <= 1'b0;
                err_lane_o  <= '0;
                err_cycle_o <= '0;
                err_xor_o   <= '0;
            end
            if (clr_i) begin
                mismatch_cnt_o <= cmp_mis ? CNT_W'(1) : '0;
            end else if (cmp_mis && mismatch_cnt_o != '1) begin
                mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule
